// File: rtl/sram_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_bist_pkg
// Purpose  : Shared types and March C- element tables for the SRAM BIST
//            initiator (sram_march_bist) and its compare unit.
// Contents : state_t controller states, elem_t element index (E0..E5),
//            per-element tables for direction, op count and op polarity.
// Revision : 1.0 - initial release
// ============================================================================
package sram_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef logic [2:0] elem_t;

  localparam elem_t E0 = 3'd0;  // up   (w0)
  localparam elem_t E1 = 3'd1;  // up   (r0, w1)
  localparam elem_t E2 = 3'd2;  // up   (r1, w0)
  localparam elem_t E3 = 3'd3;  // down (r0, w1)
  localparam elem_t E4 = 3'd4;  // down (r1, w0)
  localparam elem_t E5 = 3'd5;  // up   (r0)

  // Tables are indexed by element number; bits 6 and 7 are unused padding so
  // any 3-bit index stays in range.
  localparam logic [7:0] ELEM_UP      = 8'b0010_0111;  // 1 = ascending addresses
  localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;  // 1 = two ops per address
  localparam logic [7:0] OP0_READ     = 8'b0011_1110;  // first op is a read
  localparam logic [7:0] OP0_BIT      = 8'b0001_0100;  // first op data: 1 = ~BG
  localparam logic [7:0] OP1_BIT      = 8'b0000_1010;  // second op (always write)

  function automatic logic op_is_read(input elem_t e, input logic op);
    return op ? 1'b0 : OP0_READ[e];
  endfunction

  function automatic logic op_bit(input elem_t e, input logic op);
    return op ? OP1_BIT[e] : OP0_BIT[e];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bist_cmp.sv
`default_nettype none
// ============================================================================
// Module   : sram_bist_cmp
// Purpose  : Expected-data pipeline and compare/capture for the SRAM BIST.
//            Each issued read pushes {expected, address, element}; when the
//            entry reaches the end of the READ_LAT-deep pipe, Q is compared.
// Ports    : clk_i, rst_i (async, active high), clr_i (clear results),
//            push_i/exp_i/addr_i/elem_i (read issued this cycle), q_i (macro
//            read data), fail_o/fail_addr_o/fail_elem_o/fail_data_o (first
//            mismatch), err_count_o (saturating mismatch count).
// Revision : 1.0 - initial release
// ============================================================================
module sram_bist_cmp
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  elem_t             elem_i,
  input  logic [DATA_W-1:0] q_i,
  output logic              fail_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [2:0]        fail_elem_o,
  output logic [DATA_W-1:0] fail_data_o,
  output logic [CNT_W-1:0]  err_count_o
);

  logic [READ_LAT-1:0] vld_q;
  logic [DATA_W-1:0]   exp_q  [READ_LAT];
  logic [ADDR_W-1:0]   addr_q [READ_LAT];
  elem_t               elem_q [READ_LAT];

  logic                fail_q;
  logic [ADDR_W-1:0]   fail_addr_q;
  elem_t               fail_elem_q;
  logic [DATA_W-1:0]   fail_data_q;
  logic [CNT_W-1:0]    err_q;

  logic                mis;
  assign mis = vld_q[READ_LAT-1] && (q_i != exp_q[READ_LAT-1]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < READ_LAT; i++) begin
        vld_q[i]  <= 1'b0;
        exp_q[i]  <= '0;
        addr_q[i] <= '0;
        elem_q[i] <= '0;
      end
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_data_q <= '0;
      err_q       <= '0;
    end else begin
      vld_q[0]  <= push_i;
      exp_q[0]  <= exp_i;
      addr_q[0] <= addr_i;
      elem_q[0] <= elem_i;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        exp_q[i]  <= exp_q[i-1];
        addr_q[i] <= addr_q[i-1];
        elem_q[i] <= elem_q[i-1];
      end
      // clr only arrives in IDLE, when the pipe is already empty, so it
      // never competes with a live compare.
      if (clr_i) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_elem_q <= '0;
        fail_data_q <= '0;
        err_q       <= '0;
      end else if (mis) begin
        if (err_q != {CNT_W{1'b1}}) begin
          err_q <= err_q + 1'b1;
        end
        if (!fail_q) begin
          fail_q      <= 1'b1;
          fail_addr_q <= addr_q[READ_LAT-1];
          fail_elem_q <= elem_q[READ_LAT-1];
          fail_data_q <= q_i;
        end
      end
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;
  assign fail_data_o = fail_data_q;
  assign err_count_o = err_q;

endmodule
`default_nettype wire

// File: rtl/sram_march_bist.sv
`default_nettype none
// ============================================================================
// Module   : sram_march_bist
// Purpose  : March C- BIST initiator for a single-port SRAM macro. Drives the
//            macro BIST port one op per cycle and checks read data.
// Ports    : CLK, RST (async, active high), start (pulse, ignored when busy);
//            macro side BIST, CEBM, WEBM, AM, DM, BWEBM (all registered), Q;
//            status busy, done, fail, fail_addr, fail_elem, fail_data,
//            err_count.
// Revision : 1.0 - initial release
// ============================================================================
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int                ADDR_W   = 11,
  parameter int                DATA_W   = 32,
  parameter int                READ_LAT = 1,
  parameter logic [DATA_W-1:0] BG       = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              BIST,
  output logic              CEBM,
  output logic              WEBM,
  output logic [ADDR_W-1:0] AM,
  output logic [DATA_W-1:0] DM,
  output logic [DATA_W-1:0] BWEBM,
  input  logic [DATA_W-1:0] Q,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam int                DRN_W    = $clog2(READ_LAT + 1);

  // The output registers always hold the op being presented; elem_q/op_q/
  // am_q identify it, and the *_d signals name the op that follows.
  state_t            state_q;
  elem_t             elem_q;
  logic              op_q;
  logic [ADDR_W-1:0] am_q;
  logic [DATA_W-1:0] dm_q;
  logic              cebm_q;
  logic              webm_q;
  logic              busy_q;
  logic              done_q;
  logic [DRN_W-1:0]  drn_q;

  elem_t             elem_d;
  logic              op_d;
  logic [ADDR_W-1:0] addr_d;
  logic              last_op;

  always_comb begin
    elem_d  = elem_q;
    op_d    = 1'b0;
    addr_d  = am_q;
    last_op = (elem_q == E5) && (am_q == ADDR_MAX);
    if (ELEM_TWO_OPS[elem_q] && !op_q) begin
      op_d = 1'b1;
    end else if (ELEM_UP[elem_q] ? (am_q == ADDR_MAX) : (am_q == '0)) begin
      // Element boundary: reload the address for the next element's direction.
      elem_d = elem_q + 3'd1;
      addr_d = ELEM_UP[elem_d] ? '0 : ADDR_MAX;
    end else begin
      addr_d = ELEM_UP[elem_q] ? am_q + 1'b1 : am_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      elem_q  <= E0;
      op_q    <= 1'b0;
      am_q    <= '0;
      dm_q    <= '0;
      cebm_q  <= 1'b1;
      webm_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drn_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            elem_q  <= E0;
            op_q    <= 1'b0;
            am_q    <= '0;
            dm_q    <= op_bit(E0, 1'b0) ? ~BG : BG;
            cebm_q  <= 1'b0;
            webm_q  <= op_is_read(E0, 1'b0);
            drn_q   <= '0;
          end
        end
        ST_RUN: begin
          if (last_op) begin
            state_q <= ST_DRAIN;
            cebm_q  <= 1'b1;
            webm_q  <= 1'b1;
            drn_q   <= '0;
          end else begin
            elem_q  <= elem_d;
            op_q    <= op_d;
            am_q    <= addr_d;
            dm_q    <= op_bit(elem_d, op_d) ? ~BG : BG;
            webm_q  <= op_is_read(elem_d, op_d);
          end
        end
        ST_DRAIN: begin
          // Wait for the last read's data to reach the comparator.
          if (drn_q == DRN_W'(READ_LAT - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drn_q <= drn_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cebm_q  <= 1'b1;
          webm_q  <= 1'b1;
        end
      endcase
    end
  end

  sram_bist_cmp #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT),
    .CNT_W    (CNT_W)
  ) u_cmp (
    .clk_i       (CLK),
    .rst_i       (RST),
    .clr_i       ((state_q == ST_IDLE) && start),
    .push_i      (!cebm_q && webm_q),
    .exp_i       (dm_q),
    .addr_i      (am_q),
    .elem_i      (elem_q),
    .q_i         (Q),
    .fail_o      (fail),
    .fail_addr_o (fail_addr),
    .fail_elem_o (fail_elem),
    .fail_data_o (fail_data),
    .err_count_o (err_count)
  );

  assign BIST  = busy_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign CEBM  = cebm_q;
  assign WEBM  = webm_q;
  assign AM    = am_q;
  assign DM    = dm_q;
  assign BWEBM = '0;

endmodule
`default_nettype wire

// File: tb/tb_sram_march_bist.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sram_march_bist
// Purpose  : Testbench for sram_march_bist on an 8x32 behavioural macro.
//            Two instances (BG = 0 and BG = A5A5A5A5) share clock, reset and
//            start; each has its own macro model with injectable faults.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_march_bist;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int RL = 1;
  localparam int CW = 16;
  localparam int N  = 8;
  localparam logic [DW-1:0] BG0 = 32'h0000_0000;
  localparam logic [DW-1:0] BG1 = 32'hA5A5_A5A5;

  localparam logic [126:0] RST_VAL = {1'b0, 1'b1, 1'b1, {AW{1'b0}}, {DW{1'b0}},
                                      {DW{1'b0}}, 1'b0, 1'b0, 1'b0, {AW{1'b0}},
                                      3'b000, {DW{1'b0}}, {CW{1'b0}}};

  typedef struct {
    bit sa_en;  int sa_addr; int sa_bit; bit sa_val;
    bit cf_en;  int cf_aggr; int cf_vic; int cf_bit;
  } fault_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic start = 1'b0;
  always #5 CLK = ~CLK;

  logic bist0, cebm0, webm0, busy0, done0, fail0;
  logic [AW-1:0] am0, fa0;
  logic [DW-1:0] dm0, bweb0, fd0;
  logic [DW-1:0] q0 = '0;
  logic [2:0] fe0;
  logic [CW-1:0] ec0;
  logic bist1, cebm1, webm1, busy1, done1, fail1;
  logic [AW-1:0] am1, fa1;
  logic [DW-1:0] dm1, bweb1, fd1;
  logic [DW-1:0] q1 = '0;
  logic [2:0] fe1;
  logic [CW-1:0] ec1;

  sram_march_bist #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .BG(BG0), .CNT_W(CW)) dut0 (
    .CLK(CLK), .RST(RST), .start(start), .BIST(bist0), .CEBM(cebm0), .WEBM(webm0),
    .AM(am0), .DM(dm0), .BWEBM(bweb0), .Q(q0), .busy(busy0), .done(done0),
    .fail(fail0), .fail_addr(fa0), .fail_elem(fe0), .fail_data(fd0), .err_count(ec0));

  sram_march_bist #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .BG(BG1), .CNT_W(CW)) dut1 (
    .CLK(CLK), .RST(RST), .start(start), .BIST(bist1), .CEBM(cebm1), .WEBM(webm1),
    .AM(am1), .DM(dm1), .BWEBM(bweb1), .Q(q1), .busy(busy1), .done(done1),
    .fail(fail1), .fail_addr(fa1), .fail_elem(fe1), .fail_data(fd1), .err_count(ec1));

  logic [126:0] outs0, outs1;
  logic [55:0]  res0, res1;
  assign outs0 = {bist0, cebm0, webm0, am0, dm0, bweb0, busy0, done0, fail0, fa0, fe0, fd0, ec0};
  assign outs1 = {bist1, cebm1, webm1, am1, dm1, bweb1, busy1, done1, fail1, fa1, fe1, fd1, ec1};
  assign res0  = {done0, fail0, fa0, fe0, fd0, ec0};
  assign res1  = {done1, fail1, fa1, fe1, fd1, ec1};

  // ---------------- behavioural macros with fault injection ----------------
  fault_t flt0, flt1;
  logic [DW-1:0] mem0 [N];
  logic [DW-1:0] mem1 [N];

  function automatic logic [DW-1:0] f_read(input fault_t f, input int a, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (f.sa_en && a == f.sa_addr) r[f.sa_bit] = f.sa_val;
    return r;
  endfunction

  always @(posedge CLK) begin
    if (cebm0 === 1'b0) begin
      if (webm0 === 1'b0) begin
        mem0[am0] <= dm0;
        if (flt0.cf_en && int'(am0) == flt0.cf_aggr)
          mem0[flt0.cf_vic][flt0.cf_bit] <= ~mem0[flt0.cf_vic][flt0.cf_bit];
      end else begin
        q0 <= f_read(flt0, int'(am0), mem0[am0]);
      end
    end
  end

  always @(posedge CLK) begin
    if (cebm1 === 1'b0) begin
      if (webm1 === 1'b0) begin
        mem1[am1] <= dm1;
        if (flt1.cf_en && int'(am1) == flt1.cf_aggr)
          mem1[flt1.cf_vic][flt1.cf_bit] <= ~mem1[flt1.cf_vic][flt1.cf_bit];
      end else begin
        q1 <= f_read(flt1, int'(am1), mem1[am1]);
      end
    end
  end

  // Op trace of dut0: {WEBM, AM, DM for writes / 0 for reads}
  bit            trace_en = 1'b0;
  logic [35:0]   trace_q   [$];
  logic [35:0]   exp_trace [$];
  always @(posedge CLK) begin
    if (trace_en && cebm0 === 1'b0)
      trace_q.push_back({webm0, am0, (webm0 ? 32'h0 : dm0)});
  end

  // ---------------- March C- reference model ----------------
  // op codes: 0 = r0, 1 = r1, 2 = w0, 3 = w1, -1 = none
  int m_up  [6]    = '{1, 1, 1, 0, 0, 1};
  int m_ops [6][2] = '{'{2, -1}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, -1}};

  function automatic logic [55:0] ref_march(input logic [DW-1:0] bg, input fault_t f,
                                            input bit want_trace);
    logic [DW-1:0] m [N];
    logic [DW-1:0] d, r, fdv;
    logic [AW-1:0] fa;
    logic [2:0]    fe;
    bit            fl;
    int            errs;
    fl = 1'b0; fa = '0; fe = '0; fdv = '0; errs = 0;
    for (int i = 0; i < N; i++) m[i] = '0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        int a;
        a = (m_up[e] != 0) ? i : N - 1 - i;
        for (int k = 0; k < 2; k++) begin
          int op;
          op = m_ops[e][k];
          if (op >= 0) begin
            d = op[0] ? ~bg : bg;
            if (op < 2) begin
              r = f_read(f, a, m[a]);
              if (r !== d) begin
                errs++;
                if (!fl) begin fl = 1'b1; fa = AW'(a); fe = 3'(e); fdv = r; end
              end
              if (want_trace) exp_trace.push_back({1'b1, AW'(a), 32'h0});
            end else begin
              m[a] = d;
              if (f.cf_en && a == f.cf_aggr) m[f.cf_vic][f.cf_bit] = ~m[f.cf_vic][f.cf_bit];
              if (want_trace) exp_trace.push_back({1'b0, AW'(a), d});
            end
          end
        end
      end
    end
    return {1'b1, fl, fa, fe, fdv, CW'(errs)};
  endfunction

  // ---------------- checking helpers ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Counts negedges with busy high; optionally hammers start while busy.
  task automatic run_wait(input bit spam, output int cyc);
    cyc = 0;
    while (busy0 === 1'b1 && cyc < 2000) begin
      cyc++;
      if (spam) start = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    start = 1'b0;
  endtask

  function automatic logic [35:0] trace_at(input int idx);
    if (idx >= 0 && idx < trace_q.size()) return trace_q[idx];
    return 36'hF_FFFF_FFFF;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            cyc;
    int            nbad;
    logic [55:0]   e0, e1;
    fault_t        nof;
    logic [55:0]   pass_res;

    nof = '{default: 0};
    flt0 = nof; flt1 = nof;
    pass_res = {1'b1, 1'b0, {AW{1'b0}}, 3'b000, {DW{1'b0}}, {CW{1'b0}}};

    // Reset state
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_dut0", outs0, RST_VAL);
    chk("reset_dut1", outs1, RST_VAL);
    RST = 1'b0;
    @(negedge CLK);

    // Run A: fault-free, trace captured on dut0
    e0 = ref_march(BG0, flt0, 1'b1);
    e1 = ref_march(BG1, flt1, 1'b0);
    trace_en = 1'b1;
    start_pulse();
    run_wait(1'b0, cyc);
    trace_en = 1'b0;
    chk("A_busy_cycles", cyc, 80 + RL);
    chk("A_res0", res0, e0);
    chk("A_res0_pass", res0, pass_res);
    chk("A_res1", res1, e1);
    chk("A_busy1_low", busy1, 1'b0);
    chk("A_trace_len", trace_q.size(), 10 * N);
    chk("A_first_op", trace_at(0), {1'b0, 3'd0, 32'h0});
    chk("A_last_op", trace_at(10 * N - 1), {1'b1, 3'd7, 32'h0});
    nbad = 0;
    for (int i = 0; i < exp_trace.size(); i++)
      if (trace_at(i) !== exp_trace[i]) nbad++;
    chk("A_trace_seq", nbad, 0);

    // Run B: start on the cycle after done; stuck-at-1 on dut0, coupling on dut1;
    // start hammered while busy.
    flt0 = nof; flt0.sa_en = 1'b1; flt0.sa_addr = 3; flt0.sa_bit = 5; flt0.sa_val = 1'b1;
    flt1 = nof; flt1.cf_en = 1'b1; flt1.cf_aggr = 2; flt1.cf_vic = 6; flt1.cf_bit = 0;
    e0 = ref_march(BG0, flt0, 1'b0);
    e1 = ref_march(BG1, flt1, 1'b0);
    start_pulse();
    chk("B_accept", {busy0, done0, fail0, ec0}, {1'b1, 1'b0, 1'b0, 16'd0});
    run_wait(1'b1, cyc);
    chk("B_busy_cycles", cyc, 80 + RL);
    chk("B_res0", res0, e0);
    chk("B_stuck", res0, {1'b1, 1'b1, 3'd3, 3'd1, 32'h0000_0020, 16'd3});
    chk("B_res1", res1, e1);
    chk("B_cf_fail", fail1, 1'b1);

    // Run C: fault removed after a failing run
    flt0 = nof; flt1 = nof;
    start_pulse();
    run_wait(1'b0, cyc);
    chk("C_busy_cycles", cyc, 80 + RL);
    chk("C_res0", res0, pass_res);
    chk("C_res1", res1, pass_res);

    // Run D: RST mid-test, asynchronous return to reset values
    start_pulse();
    repeat (19) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("D_async_reset0", outs0, RST_VAL);
    chk("D_async_reset1", outs1, RST_VAL);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    start_pulse();
    run_wait(1'b0, cyc);
    chk("D_busy_cycles", cyc, 80 + RL);
    chk("D_res0", res0, pass_res);
    chk("D_res1", res1, pass_res);

    // Randomized faults against the reference model
    for (int r = 0; r < 4; r++) begin
      flt0 = nof;
      flt0.sa_en   = 1'b1;
      flt0.sa_addr = int'($urandom_range(0, N - 1));
      flt0.sa_bit  = int'($urandom_range(0, DW - 1));
      flt0.sa_val  = 1'($urandom_range(0, 1));
      flt1 = nof;
      flt1.cf_en   = 1'b1;
      flt1.cf_aggr = int'($urandom_range(0, N - 1));
      flt1.cf_vic  = (flt1.cf_aggr + int'($urandom_range(1, N - 1))) % N;
      flt1.cf_bit  = int'($urandom_range(0, DW - 1));
      e0 = ref_march(BG0, flt0, 1'b0);
      e1 = ref_march(BG1, flt1, 1'b0);
      repeat ($urandom_range(0, 5)) @(negedge CLK);
      start_pulse();
      run_wait(1'($urandom_range(0, 1)), cyc);
      chk($sformatf("R%0d_busy_cycles", r), cyc, 80 + RL);
      chk($sformatf("R%0d_res0", r), res0, e0);
      chk($sformatf("R%0d_res1", r), res1, e1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
- Built-in self-test initiator for the 2048x32 single-port SRAM macro in MyAccelerator.
- Drives the macro's BIST-mode port (BIST, CEBM, WEBM, AM, DM, BWEBM) and checks Q against expected data.
- Runs a March C- sequence and reports pass/fail, the first failing address/element/data, and an error count.
- Sits beside the accelerator's normal-mode SRAM master. The top level ties the macro's BIST pin to this block's BIST output.

Parameters:
- ADDR_W, 11, address width; test covers addresses 0 .. 2^ADDR_W-1.
- DATA_W, 32, data width of DM/Q.
- READ_LAT, 1, edges from read-issue edge to the sampling edge for Q (macro: Q valid after issue edge, sampled on next edge).
- BG, {DATA_W{1'b0}}, data background. "0" writes BG; "1" writes ~BG.
- CNT_W, 16, err_count width.

Ports:
- CLK, input, 1: clock, rising edge.
- RST, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle pulse; begins a test when not busy.
- BIST, output, 1: macro mode select; 1 while busy.
- CEBM, output, 1: chip enable, active low.
- WEBM, output, 1: 0 = write, 1 = read.
- AM, output, ADDR_W: address.
- DM, output, DATA_W: write data.
- BWEBM, output, DATA_W: bit write enable, active low; all zeros during writes and reads.
- Q, input, DATA_W: macro read data.
- busy, output, 1: test in progress (RUN or DRAIN).
- done, output, 1: level; set when the test completes, cleared by the next accepted start.
- fail, output, 1: sticky mismatch flag, valid with done.
- fail_addr, output, ADDR_W: address of the first mismatch.
- fail_elem, output, 3: March element index (0-5) of the first mismatch.
- fail_data, output, DATA_W: Q captured at the first mismatch.
- err_count, output, CNT_W: number of mismatching reads, saturating at all-ones.

Behaviour:
- Reset values: BIST=0, CEBM=1, WEBM=1, AM=0, DM=0, BWEBM=0, busy=0, done=0, fail=0, fail_addr=0, fail_elem=0, fail_data=0, err_count=0. The compare pipeline is cleared.
- All macro-side outputs are registered.
- States and transitions:
  - IDLE -> RUN on start. Accepting start clears done, fail, err_count and the fail_* outputs.
  - RUN -> DRAIN after the final op issues.
  - DRAIN holds READ_LAT cycles, then -> IDLE with done=1.
  - start is ignored while busy.
- March C- elements (direction; ops per address, in order):
  - E0 up (w0)
  - E1 up (r0, w1)
  - E2 up (r1, w0)
  - E3 down (r0, w1)
  - E4 down (r1, w0)
  - E5 up (r0)
- Op data: 0 = BG, 1 = ~BG. "up" runs address 0..max; "down" runs max..0.
- Issue rate: one op per cycle with no bubbles, including element boundaries and the r->w pair to the same address.
- Total RUN cycles: 10*2^ADDR_W.
- CEBM is 0 exactly on issue cycles. It is 1 in IDLE and DRAIN.
- Compare: each read pushes {expected, AM, element} into a READ_LAT-deep shift register. When the entry emerges, Q is compared with expected.
- On mismatch:
  - err_count increments, saturating.
  - On the first mismatch only, fail sets and fail_addr, fail_elem and fail_data are captured.
- The test runs to completion regardless of failures.
- The address counter wraps at element end, reloading to 0 or max per direction. No out-of-range address is ever driven.
- RST mid-test: immediate abort to reset values; the SRAM contents are undefined afterwards.
- start in the same cycle as the last DRAIN cycle: ignored. start on the cycle after done rises: accepted.

Decomposition:
- Package sram_bist_pkg holds:
  - state enum (IDLE, RUN, DRAIN)
  - element encoding, E0..E5 = 0..5
  - per-element constant tables: direction, op count, op polarity (r/w and data bit per op)
- One sub-module, sram_bist_cmp: the READ_LAT-deep expected-data pipeline plus compare/capture logic and the saturating counter.

Test Plan:
- Fault-free behavioural 8x32 macro model (ADDR_W=3, BG=0); pulse start.
  - busy high for exactly 80+READ_LAT cycles, then done=1, fail=0, err_count=0.
  - First write: AM=0, DM=0. Last read: AM=7, expecting 0.
- Stuck-at-1 on bit 5 of address 3, same setup.
  - fail=1, fail_elem=1, fail_addr=3, fail_data=32'h0000_0020.
  - err_count=3: E1, E3 and E5 each read 0 and see 1.
- Coupling fault: writing address 2 flips bit 0 of address 6, BG=32'hA5A5A5A5.
  - fail=1, and fail_addr/fail_elem match the first detecting read predicted by a March C- reference model.
- RST asserted 20 cycles after start, then released.
  - All outputs return to reset values in the same cycle as RST rises, asynchronously.
  - A new start runs to done=1, fail=0.
- start pulsed repeatedly while busy: ignored; cycle count unchanged.
- start pulsed after a failing run, then fault removed: done=1, fail=0, err_count=0.
